char_stream_sequencer: RTL and testbench
========================================

Name: char_stream_sequencer

Overview:
Sequences the 80-entry character-string ROM, which has a 2-cycle registered read path and no read enable. It issues ROM addresses 0..NUM_CHARS-1 in order and tracks in-flight reads with a valid shift pipeline. Returned character codes are buffered in a small FIFO and presented to the pixel/glyph generator over a valid/ready stream. A credit rule guarantees no returned code is ever dropped under downstream back-pressure.

Parameters:
NUM_CHARS, 80, number of ROM entries fetched per run
ADDR_W, 7, ROM address width
DATA_W, 7, character code width
ROM_LAT, 2, clocks from address presented to data on rom_data
FIFO_DEPTH, 4, output buffer entries; must be >= ROM_LAT+1 (elaboration error otherwise)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle request to begin a run
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse after the final beat handshakes
rom_addr  out  ADDR_W  address to ROM
rom_data  in  DATA_W  ROM output, valid ROM_LAT clocks after the address
out_valid  out  1  stream valid
out_ready  in  1  stream ready from consumer
out_data  out  DATA_W  character code
out_index  out  ADDR_W  position (0..NUM_CHARS-1) of out_data
out_last  out  1  high with the beat whose out_index == NUM_CHARS-1

Behaviour:
- Reset: state IDLE; busy=0, done=0, out_valid=0, rom_addr=0, issue counter=0, valid pipeline cleared, FIFO empty. rst mid-run abandons the run; in-flight ROM data is ignored.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start. busy=1 from the next cycle.
  - RUN -> DRAIN on the edge that issues index NUM_CHARS-1.
  - DRAIN -> IDLE when the valid pipeline is empty, the FIFO is empty and no beat is pending. done pulses in the first IDLE cycle.
- start while busy is ignored (no queuing).
- Issue rule (RUN only), evaluated each cycle: issue when fifo_count + inflight < FIFO_DEPTH.
  - inflight = number of set bits in the ROM_LAT-deep valid pipeline.
  - A pop in the same cycle is not credited (conservative rule).
  - On issue, rom_addr carries the issue counter; a 1 enters the pipeline together with the index; the counter increments.
  - With no issue, rom_addr holds its value and a 0 enters the pipeline.
- Capture: when the pipeline tail bit is 1, rom_data and its index are written into the FIFO on that edge.
  - The credit rule guarantees the FIFO is never full at capture; an assertion covers this.
- Stream:
  - out_valid = FIFO not empty.
  - out_data, out_index and out_last come from the FIFO head.
  - A pop occurs on out_valid && out_ready.
  - Simultaneous push and pop leaves the count unchanged.
  - out_data is stable while out_valid=1 and out_ready=0.
- Latency: start sampled at edge E0 -> rom_addr=0 presented after E0 -> captured at E0+1+ROM_LAT. First out_valid is high in the cycle after E3 (default parameters).
- Throughput: 1 beat/clk when out_ready is held high.
- Wrap-around: the issue counter stops at NUM_CHARS-1; it is never wrapped within a run and is reset to 0 on the next start.
- Codes pass through unmodified, including control codes 13 and 10; interpreting them is the consumer's job.

Decomposition:
- Shared package: ROM_LAT, NUM_CHARS, and the ADDR_W/DATA_W widths shared with the ROM and glyph generator; FSM state enum.
- One natural sub-module: sync_fifo (depth/width parameterised, count output). The valid/index pipeline stays inline.

Test Plan:
- Reset, then start with out_ready=1:
  - first out_valid 3 cycles after the start edge;
  - out_data index 0..3 = 116,104,101,32;
  - 80 consecutive beats; out_last only at index 79 (data 32);
  - done pulses one cycle after that handshake; busy=0 afterwards.
- out_ready held low throughout a run:
  - exactly FIFO_DEPTH=4 ROM reads issued, no further address advance;
  - out_data=116 held stable;
  - releasing ready delivers all 80 codes in order with none missing or duplicated.
- Random out_ready (50%): the sequence matches the ROM contents at every index, including index 0x3E=13, 0x3F=10 and 0x40=84; the FIFO-overflow assertion never fires.
- start pulsed again at cycle 20 of a run: ignored; the run completes with exactly 80 beats and one done pulse.
- rst asserted mid-run at index 40 with data in flight:
  - next cycle out_valid=0, busy=0, no done;
  - a following start restarts from index 0 (data 116).
- Back-to-back runs: start in the cycle done pulses is accepted; the second run's first beat is 116.

Source files
------------

// File: rtl/char_stream_sequencer_pkg.sv
// Widths, run length and ROM latency shared with the string ROM and the glyph generator.
package char_stream_sequencer_pkg;

    localparam int unsigned NumChars         = 80;
    localparam int unsigned AddrW            = 7;
    localparam int unsigned DataW            = 7;
    localparam int unsigned RomLat           = 2;
    localparam int unsigned FifoDepthDefault = 4;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

endpackage

// File: rtl/char_stream_sequencer_if.sv
// Valid/ready character stream from the sequencer to the glyph generator.
interface char_stream_sequencer_if;
    import char_stream_sequencer_pkg::*;

    logic             valid;
    logic             ready;
    logic [DataW-1:0] data;
    logic [AddrW-1:0] index;
    logic             last;

    modport master (output valid, data, index, last, input ready);
    modport slave  (input valid, data, index, last, output ready);

endinterface

// File: rtl/char_stream_sequencer_sync_fifo.sv
// Synchronous FIFO with a fill-count output; rdata always shows the head entry.
module char_stream_sequencer_sync_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 8,
    parameter int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    output logic [Width-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic [CntW-1:0]  count
);
    localparam int unsigned     PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             push_en, pop_en;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CntW'(Depth));
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
            end
            if (pop_en) begin
                rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
            end
            if (push_en && !pop_en) begin
                count_q <= count_q + CntW'(1);
            end else if (pop_en && !push_en) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/char_stream_sequencer.sv
// Reads every entry of the string ROM in order and streams the codes out, issuing a read
// only when the output FIFO is certain to have room for its data.
module char_stream_sequencer
    import char_stream_sequencer_pkg::*;
#(
    parameter int unsigned FifoDepth = FifoDepthDefault
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [AddrW-1:0]        rom_addr,
    input  logic [DataW-1:0]        rom_data,
    char_stream_sequencer_if.master out
);
    localparam int unsigned      CntW    = $clog2(FifoDepth + 1);
    localparam logic [AddrW-1:0] LastIdx = AddrW'(NumChars - 1);

    if (FifoDepth < RomLat + 1 || RomLat < 2) begin : g_param_check
        $error("FifoDepth must be at least RomLat + 1 and RomLat at least 2");
    end

    state_e                        state_q, state_d;
    logic   [AddrW-1:0]            cnt_q, cnt_d;
    logic                          done_q, done_d;
    logic   [RomLat-1:0]           vld_pipe_q;
    logic   [RomLat-1:0][AddrW-1:0] idx_pipe_q;

    logic   [CntW-1:0]             fifo_count;
    logic                          fifo_empty, fifo_full;
    logic   [AddrW+DataW-1:0]      fifo_rdata;
    logic                          issue, push, pop, head_valid;
    logic   [AddrW-1:0]            head_index;
    logic   [DataW-1:0]            head_data;

    assign push       = vld_pipe_q[RomLat-1];
    assign head_valid = !fifo_empty;
    assign pop        = head_valid && out.ready;
    // Pops are not credited: every read in flight already owns a free FIFO slot.
    assign issue = (state_q == StRun) &&
                   ((32'(fifo_count) + 32'($countones(vld_pipe_q))) < FifoDepth);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                if (issue) begin
                    if (cnt_q == LastIdx) begin
                        state_d = StDrain;
                    end else begin
                        cnt_d = cnt_q + AddrW'(1);
                    end
                end
            end
            StDrain: begin
                // Leave on the edge that pops the final beat so done follows it directly.
                if (vld_pipe_q == '0 && (fifo_empty || (fifo_count == CntW'(1) && pop))) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            vld_pipe_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            vld_pipe_q <= {vld_pipe_q[RomLat-2:0], issue};
        end
    end

    always_ff @(posedge clk) begin
        idx_pipe_q <= {idx_pipe_q[RomLat-2:0], cnt_q};
    end

    char_stream_sequencer_sync_fifo #(
        .Depth (FifoDepth),
        .Width (AddrW + DataW),
        .CntW  (CntW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({idx_pipe_q[RomLat-1], rom_data}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign {head_index, head_data} = fifo_rdata;

    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign rom_addr  = cnt_q;
    assign out.valid = head_valid;
    assign out.data  = head_data;
    assign out.index = head_index;
    assign out.last  = head_valid && (head_index == LastIdx);

    assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));

endmodule

// File: tb/tb_char_stream_sequencer.sv
// Directed bench: a 2-cycle registered string ROM model feeds the sequencer and each task
// checks one behaviour of the resulting character stream.
module tb_char_stream_sequencer;
    import char_stream_sequencer_pkg::*;

    localparam int ModeHigh    = 0;
    localparam int ModeRand    = 1;
    localparam int ModeRestart = 2;
    localparam int ModeChain   = 3;

    logic             clk   = 1'b0;
    logic             rst   = 1'b1;
    logic             start = 1'b0;
    logic             busy, done;
    logic [AddrW-1:0] rom_addr;
    logic [DataW-1:0] rom_data, rom_q1;

    char_stream_sequencer_if sif ();

    char_stream_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .out      (sif)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [DataW-1:0] beat_data [128];
    logic [AddrW-1:0] beat_idx  [128];
    logic             beat_last [128];
    int beat_n, done_n, first_valid, last_hs, done_at;

    always #5 clk = ~clk;

    // "the " at the head, CR LF 'T' in the middle, a space at the very end.
    function automatic logic [DataW-1:0] rom_code(input int i);
        case (i)
            0:       return 7'd116;
            1:       return 7'd104;
            2:       return 7'd101;
            3:       return 7'd32;
            62:      return 7'd13;
            63:      return 7'd10;
            64:      return 7'd84;
            79:      return 7'd32;
            default: return 7'(65 + (i % 26));
        endcase
    endfunction

    always @(posedge clk) begin
        rom_q1   <= rom_code(int'(rom_addr));
        rom_data <= rom_q1;
    end

    // Runs one stream; the caller raises start just before. Cycle k is the k-th falling
    // edge after the edge that sampled start.
    task automatic collect(input int mode, input int budget, output bit got_done);
        beat_n = 0; done_n = 0; first_valid = -1; last_hs = -1; done_at = -1;
        got_done = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            start     = (mode == ModeRestart && k == 20);
            sif.ready = (mode == ModeRand) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sif.valid && first_valid < 0) first_valid = k - 1;
            if (sif.valid && sif.ready) begin
                if (beat_n < 128) begin
                    beat_data[beat_n] = sif.data;
                    beat_idx[beat_n]  = sif.index;
                    beat_last[beat_n] = sif.last;
                end
                beat_n++;
                last_hs = k;
            end
            if (done) begin
                done_n++;
                if (done_at < 0) done_at = k;
                if (mode == ModeChain) begin
                    start    = 1'b1;
                    got_done = 1'b1;
                    return;
                end
            end
            if (done_at > 0 && k >= done_at + 3) break;
        end
        got_done = (done_at > 0);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sif.ready = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
        vectors++; if (sif.valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", sif.valid); end
        vectors++; if (rom_addr !== 7'd0) begin miscompares++; $display("FAIL reset_rom_addr: got %0d want 0", rom_addr); end
        rst = 1'b0;
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_stream();
        bit got;
        logic [DataW-1:0] head [4];
        head = '{7'd116, 7'd104, 7'd101, 7'd32};
        @(negedge clk); start = 1'b1; sif.ready = 1'b1;
        collect(ModeHigh, 300, got);
        vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL stream_done_seen: got %b want 1", got); end
        vectors++; if (first_valid != 3) begin miscompares++; $display("FAIL stream_first_valid: got %0d want 3", first_valid); end
        vectors++; if (beat_n != 80) begin miscompares++; $display("FAIL stream_beats: got %0d want 80", beat_n); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (beat_data[i] !== head[i]) begin
                miscompares++; $display("FAIL stream_head[%0d]: got %0d want %0d", i, beat_data[i], head[i]);
            end
        end
        for (int i = 0; i < 80 && i < beat_n; i++) begin
            vectors++;
            if (beat_idx[i] !== 7'(i) || beat_data[i] !== rom_code(i) || beat_last[i] !== (i == 79)) begin
                miscompares++;
                $display("FAIL stream_beat[%0d]: got idx %0d data %0d last %b want idx %0d data %0d last %b",
                         i, beat_idx[i], beat_data[i], beat_last[i], i, rom_code(i), (i == 79));
            end
        end
        vectors++; if (last_hs != first_valid + 80) begin miscompares++; $display("FAIL stream_rate: last beat cycle %0d want %0d", last_hs, first_valid + 80); end
        vectors++; if (done_at != last_hs + 1) begin miscompares++; $display("FAIL stream_done_cycle: got %0d want %0d", done_at, last_hs + 1); end
        vectors++; if (done_n != 1) begin miscompares++; $display("FAIL stream_done_pulses: got %0d want 1", done_n); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL stream_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_ready_low();
        bit got;
        bit hold_ok = 1'b1;
        @(negedge clk); start = 1'b1; sif.ready = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k >= 4 && !(sif.valid === 1'b1 && sif.data === 7'd116 && sif.index === 7'd0)) hold_ok = 1'b0;
        end
        vectors++; if (rom_addr !== 7'd4) begin miscompares++; $display("FAIL stall_rom_addr: got %0d want 4", rom_addr); end
        vectors++; if (hold_ok !== 1'b1) begin miscompares++; $display("FAIL stall_hold_116: got data %0d want 116 held", sif.data); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL stall_busy: got %b want 1", busy); end
        collect(ModeHigh, 400, got);
        vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL stall_done_seen: got %b want 1", got); end
        vectors++; if (beat_n != 80) begin miscompares++; $display("FAIL stall_beats: got %0d want 80", beat_n); end
        for (int i = 0; i < 80 && i < beat_n; i++) begin
            vectors++;
            if (beat_idx[i] !== 7'(i) || beat_data[i] !== rom_code(i)) begin
                miscompares++;
                $display("FAIL stall_beat[%0d]: got idx %0d data %0d want idx %0d data %0d",
                         i, beat_idx[i], beat_data[i], i, rom_code(i));
            end
        end
    endtask

    task automatic test_random_ready();
        bit got;
        @(negedge clk); start = 1'b1;
        collect(ModeRand, 1500, got);
        vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL rand_done_seen: got %b want 1", got); end
        vectors++; if (beat_n != 80) begin miscompares++; $display("FAIL rand_beats: got %0d want 80", beat_n); end
        vectors++; if (done_n != 1) begin miscompares++; $display("FAIL rand_done_pulses: got %0d want 1", done_n); end
        vectors++; if (beat_data[62] !== 7'd13) begin miscompares++; $display("FAIL rand_cr: got %0d want 13", beat_data[62]); end
        vectors++; if (beat_data[63] !== 7'd10) begin miscompares++; $display("FAIL rand_lf: got %0d want 10", beat_data[63]); end
        vectors++; if (beat_data[64] !== 7'd84) begin miscompares++; $display("FAIL rand_t: got %0d want 84", beat_data[64]); end
        for (int i = 0; i < 80 && i < beat_n; i++) begin
            vectors++;
            if (beat_idx[i] !== 7'(i) || beat_data[i] !== rom_code(i) || beat_last[i] !== (i == 79)) begin
                miscompares++;
                $display("FAIL rand_beat[%0d]: got idx %0d data %0d last %b want idx %0d data %0d",
                         i, beat_idx[i], beat_data[i], beat_last[i], i, rom_code(i));
            end
        end
    endtask

    task automatic test_restart_ignored();
        bit got;
        @(negedge clk); start = 1'b1;
        collect(ModeRestart, 300, got);
        vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL restart_done_seen: got %b want 1", got); end
        vectors++; if (beat_n != 80) begin miscompares++; $display("FAIL restart_beats: got %0d want 80", beat_n); end
        vectors++; if (done_n != 1) begin miscompares++; $display("FAIL restart_done_pulses: got %0d want 1", done_n); end
        for (int i = 0; i < 80 && i < beat_n; i++) begin
            vectors++;
            if (beat_idx[i] !== 7'(i) || beat_data[i] !== rom_code(i)) begin
                miscompares++;
                $display("FAIL restart_beat[%0d]: got idx %0d data %0d want idx %0d data %0d",
                         i, beat_idx[i], beat_data[i], i, rom_code(i));
            end
        end
    endtask

    task automatic test_reset_mid_run();
        bit got;
        bit found = 1'b0;
        bit quiet = 1'b1;
        @(negedge clk); start = 1'b1; sif.ready = 1'b1;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (sif.valid === 1'b1 && sif.index === 7'd40) found = 1'b1;
        end
        vectors++; if (found !== 1'b1) begin miscompares++; $display("FAIL midrst_reach_40: got %b want 1", found); end
        rst = 1'b1;
        @(negedge clk);
        vectors++; if (sif.valid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid: got %b want 0", sif.valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL midrst_done: got %b want 0", done); end
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || sif.valid !== 1'b0) quiet = 1'b0;
        end
        vectors++; if (quiet !== 1'b1) begin miscompares++; $display("FAIL midrst_quiet: got %b want 1", quiet); end
        start = 1'b1;
        collect(ModeHigh, 300, got);
        vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL midrst_rerun_done: got %b want 1", got); end
        vectors++; if (beat_n != 80) begin miscompares++; $display("FAIL midrst_rerun_beats: got %0d want 80", beat_n); end
        vectors++; if (beat_idx[0] !== 7'd0 || beat_data[0] !== 7'd116) begin
            miscompares++; $display("FAIL midrst_rerun_first: got idx %0d data %0d want idx 0 data 116", beat_idx[0], beat_data[0]);
        end
    endtask

    task automatic test_back_to_back();
        bit got;
        @(negedge clk); start = 1'b1;
        collect(ModeChain, 300, got);
        vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL b2b_first_done: got %b want 1", got); end
        vectors++; if (beat_n != 80) begin miscompares++; $display("FAIL b2b_first_beats: got %0d want 80", beat_n); end
        collect(ModeHigh, 300, got);
        vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL b2b_second_done: got %b want 1", got); end
        vectors++; if (first_valid != 3) begin miscompares++; $display("FAIL b2b_second_latency: got %0d want 3", first_valid); end
        vectors++; if (beat_n != 80) begin miscompares++; $display("FAIL b2b_second_beats: got %0d want 80", beat_n); end
        vectors++; if (beat_data[0] !== 7'd116) begin miscompares++; $display("FAIL b2b_second_first: got %0d want 116", beat_data[0]); end
    endtask

    initial begin
        sif.ready = 1'b0;
        test_reset();
        test_stream();
        test_ready_low();
        test_random_ready();
        test_restart_ignored();
        test_reset_mid_run();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
